parity_frame_acc: RTL and testbench

// - Streaming parity accumulator: successor to the combinational word-parity generator.
// - Consumes N-bit words over a valid/ready stream, grouped into frames.
// - Per frame it produces three results:
//   - 1-bit frame parity, even or odd selectable.
//   - N-bit longitudinal (column) parity, LRC.
//   - Word count, plus an optional compare against an expected LRC.
// - Sits between the packet source and the link framer; feeds the error-status logic.

---
 rtl/parity_frame_acc_pkg.sv | 15 +
 rtl/parity_frame_acc_word.sv | 16 +
 rtl/parity_frame_acc.sv | 145 ++++++++++++++
 tb/tb_parity_frame_acc.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_acc_pkg.sv
// Shared definitions for the streaming parity frame accumulator.
//   - state_e        : accumulator FSM states (ACC collects words, DONE holds a result)
//   - PAR_N          : default data word width
//   - PAR_MAX_WORDS  : default maximum words per frame before force-close
package parity_frame_acc_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam int PAR_N         = 44;
  localparam int PAR_MAX_WORDS = 16;

endpackage : parity_frame_acc_pkg

// File: rtl/parity_frame_acc_word.sv
// Word parity: combinational XOR reduction of one N-bit word to a single bit.
// Shared by the frame accumulator and the downstream checker block.
//   data_i   in  N  word to reduce
//   parity_o out 1  XOR of all bits of data_i (1 = odd number of ones)
module parity_frame_acc_word
  import parity_frame_acc_pkg::*;
#(
  parameter int N = PAR_N
) (
  input  logic [N-1:0] data_i,
  output logic         parity_o
);

  assign parity_o = ^data_i;

endmodule : parity_frame_acc_word

// File: rtl/parity_frame_acc.sv
// Streaming parity accumulator. Consumes N-bit words over a valid/ready stream,
// grouped into frames closed by s_last or by reaching MAX_WORDS, and emits one
// registered result per frame: frame parity (even/odd selectable), column
// parity (LRC), word count, truncation flag and an optional LRC compare.
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data   input word stream
//   s_last                   word closes the frame
//   odd_sel                  odd parity select, taken on the frame's first beat
//   chk_en/chk_lrc           LRC compare enable/expected value, taken on the closing beat
//   m_valid/m_ready          result handshake
//   m_parity/m_lrc/m_count   frame parity, column parity, words in frame
//   m_trunc                  frame was closed by MAX_WORDS rather than s_last
//   m_err                    chk_en && (m_lrc != chk_lrc)
module parity_frame_acc
  import parity_frame_acc_pkg::*;
#(
  parameter int N         = PAR_N,
  parameter int MAX_WORDS = PAR_MAX_WORDS,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_data,
  input  logic          s_last,
  input  logic          odd_sel,
  input  logic          chk_en,
  input  logic [N-1:0]  chk_lrc,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_parity,
  output logic [N-1:0]  m_lrc,
  output logic [CW-1:0] m_count,
  output logic          m_trunc,
  output logic          m_err
);

  state_e        state_q, state_d;
  logic [N-1:0]  lrc_q, lrc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          odd_q, odd_d;

  logic          par_q, par_d;
  logic [N-1:0]  m_lrc_q, m_lrc_d;
  logic [CW-1:0] m_count_q, m_count_d;
  logic          trunc_q, trunc_d;
  logic          err_q, err_d;

  logic          in_beat;
  logic          out_beat;
  logic [N-1:0]  lrc_upd;
  logic [CW-1:0] cnt_upd;
  logic          odd_eff;
  logic          closing;
  logic          word_par;

  // While a result is held, the input is only open in the cycle the result is
  // taken, so the next frame's first word can overlap the output beat.
  assign s_ready  = (state_q == ST_ACC) || m_ready;
  assign m_valid  = (state_q == ST_DONE);
  assign in_beat  = s_valid && s_ready;
  assign out_beat = m_valid && m_ready;

  // Accumulators are always clear while in DONE, so the same update path
  // serves both a mid-frame word and a first word accepted during DONE.
  assign lrc_upd = lrc_q ^ s_data;
  assign cnt_upd = cnt_q + CW'(1);
  assign odd_eff = (cnt_q == '0) ? odd_sel : odd_q;
  assign closing = s_last || (cnt_upd == CW'(MAX_WORDS));

  // Parity of all bits in the frame equals the parity of its column parity.
  parity_frame_acc_word #(.N(N)) u_word (
    .data_i   (lrc_upd),
    .parity_o (word_par)
  );

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    lrc_d     = lrc_q;
    cnt_d     = cnt_q;
    odd_d     = odd_q;
    par_d     = par_q;
    m_lrc_d   = m_lrc_q;
    m_count_d = m_count_q;
    trunc_d   = trunc_q;
    err_d     = err_q;

    if (in_beat) begin
      if (closing) begin
        state_d   = ST_DONE;
        par_d     = word_par ^ odd_eff;
        m_lrc_d   = lrc_upd;
        m_count_d = cnt_upd;
        trunc_d   = !s_last;
        err_d     = chk_en && (lrc_upd != chk_lrc);
        lrc_d     = '0;
        cnt_d     = '0;
        odd_d     = 1'b0;
      end else begin
        state_d = ST_ACC;
        lrc_d   = lrc_upd;
        cnt_d   = cnt_upd;
        odd_d   = odd_eff;
      end
    end else if (out_beat) begin
      state_d = ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= ST_ACC;
      lrc_q     <= '0;
      cnt_q     <= '0;
      odd_q     <= 1'b0;
      par_q     <= 1'b0;
      m_lrc_q   <= '0;
      m_count_q <= '0;
      trunc_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lrc_q     <= lrc_d;
      cnt_q     <= cnt_d;
      odd_q     <= odd_d;
      par_q     <= par_d;
      m_lrc_q   <= m_lrc_d;
      m_count_q <= m_count_d;
      trunc_q   <= trunc_d;
      err_q     <= err_d;
    end
  end

  assign m_parity = par_q;
  assign m_lrc    = m_lrc_q;
  assign m_count  = m_count_q;
  assign m_trunc  = trunc_q;
  assign m_err    = err_q;

endmodule : parity_frame_acc

// File: tb/tb_parity_frame_acc.sv
// Self-checking bench for parity_frame_acc (N=44, MAX_WORDS=16).
// Table-driven frame vectors, hand-written reset/truncation/backpressure
// sequences and a randomized run, all cross-checked by a result scoreboard.
module tb_parity_frame_acc;

  localparam int N    = 44;
  localparam int MAXW = 16;
  localparam int CW   = 5;

  typedef struct packed {
    logic          parity;
    logic [N-1:0]  lrc;
    logic [CW-1:0] count;
    logic          trunc;
    logic          err;
  } res_t;

  typedef struct {
    int           nwords;
    logic [N-1:0] w [3];
    logic         odd;
    logic         chk_en;
    logic [N-1:0] chk_lrc;
    res_t         exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [N-1:0]  s_data;
  logic          s_last;
  logic          odd_sel;
  logic          chk_en;
  logic [N-1:0]  chk_lrc;
  logic          m_valid;
  logic          m_ready;
  logic          m_parity;
  logic [N-1:0]  m_lrc;
  logic [CW-1:0] m_count;
  logic          m_trunc;
  logic          m_err;

  parity_frame_acc #(.N(N), .MAX_WORDS(MAXW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .odd_sel  (odd_sel),
    .chk_en   (chk_en),
    .chk_lrc  (chk_lrc),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_parity (m_parity),
    .m_lrc    (m_lrc),
    .m_count  (m_count),
    .m_trunc  (m_trunc),
    .m_err    (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  res_t         exp_q[$];
  logic [N-1:0] mdl_lrc;
  int           mdl_cnt;
  logic         mdl_odd;
  bit           rnd_ready;
  bit           last_in_beat;
  int           words_in;
  int           count_out;
  vec_t         vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: fed with every accepted word, pushes a result per frame.
  task automatic model_in();
    res_t r;
    if (mdl_cnt == 0) mdl_odd = odd_sel;
    mdl_lrc = mdl_lrc ^ s_data;
    mdl_cnt++;
    words_in++;
    if (s_last || mdl_cnt == MAXW) begin
      r.parity = (^mdl_lrc) ^ mdl_odd;
      r.lrc    = mdl_lrc;
      r.count  = CW'(mdl_cnt);
      r.trunc  = !s_last;
      r.err    = chk_en && (mdl_lrc != chk_lrc);
      exp_q.push_back(r);
      mdl_lrc = '0;
      mdl_cnt = 0;
    end
  endtask

  task automatic compare_out();
    res_t r;
    count_out += int'(m_count);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got result lrc=%h count=%0d, expected no result", m_lrc, m_count);
    end else begin
      r = exp_q.pop_front();
      check("sb_parity", 64'(m_parity), 64'(r.parity));
      check("sb_lrc",    64'(m_lrc),    64'(r.lrc));
      check("sb_count",  64'(m_count),  64'(r.count));
      check("sb_trunc",  64'(m_trunc),  64'(r.trunc));
      check("sb_err",    64'(m_err),    64'(r.err));
    end
  endtask

  // One clock: inputs were set at the falling edge; beats are evaluated just
  // before the rising edge, then control returns at the next falling edge.
  task automatic tick();
    bit ib;
    bit ob;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    #1;
    ib = s_valid && s_ready;
    ob = m_valid && m_ready;
    last_in_beat = ib && !rst;
    if (!rst) begin
      if (ob) compare_out();
      if (ib) model_in();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [N-1:0] d, input logic last, input logic odd,
                           input logic ce, input logic [N-1:0] cl);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    odd_sel = odd;
    chk_en  = ce;
    chk_lrc = cl;
    n = 0;
    last_in_beat = 1'b0;
    while (!last_in_beat && n < 200) begin
      tick();
      n++;
    end
    if (!last_in_beat) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h not accepted after %0d cycles, expected acceptance", d, n);
    end
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    mdl_lrc = '0;
    mdl_cnt = 0;
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_s_ready"},  64'(s_ready),  64'(1));
    check({tag, "_m_valid"},  64'(m_valid),  64'(0));
    check({tag, "_m_parity"}, 64'(m_parity), 64'(0));
    check({tag, "_m_lrc"},    64'(m_lrc),    64'(0));
    check({tag, "_m_count"},  64'(m_count),  64'(0));
    check({tag, "_m_trunc"},  64'(m_trunc),  64'(0));
    check({tag, "_m_err"},    64'(m_err),    64'(0));
  endtask

  task automatic check_result(input string tag, input res_t e);
    check({tag, "_valid"},  64'(m_valid),  64'(1));
    check({tag, "_parity"}, 64'(m_parity), 64'(e.parity));
    check({tag, "_lrc"},    64'(m_lrc),    64'(e.lrc));
    check({tag, "_count"},  64'(m_count),  64'(e.count));
    check({tag, "_trunc"},  64'(m_trunc),  64'(e.trunc));
    check({tag, "_err"},    64'(m_err),    64'(e.err));
  endtask

  function automatic vec_t mkv(input int n, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] c, input logic odd, input logic ce,
                               input logic [N-1:0] cl, input logic ep, input logic [N-1:0] el,
                               input int ec, input logic ee);
    vec_t v;
    v.nwords     = n;
    v.w[0]       = a;
    v.w[1]       = b;
    v.w[2]       = c;
    v.odd        = odd;
    v.chk_en     = ce;
    v.chk_lrc    = cl;
    v.exp.parity = ep;
    v.exp.lrc    = el;
    v.exp.count  = CW'(ec);
    v.exp.trunc  = 1'b0;
    v.exp.err    = ee;
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t         e;
    logic [N-1:0] fw [20];
    logic [N-1:0] flrc;
    logic [N-1:0] fcl;
    logic [63:0]  rnd;
    logic         fce;
    int           len;
    int           n;

    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    odd_sel   = 1'b0;
    chk_en    = 1'b0;
    chk_lrc   = '0;
    m_ready   = 1'b1;
    rnd_ready = 1'b0;
    mdl_lrc   = '0;
    mdl_cnt   = 0;
    mdl_odd   = 1'b0;
    words_in  = 0;
    count_out = 0;

    // Table: n, words, odd, chk_en, chk_lrc, exp parity, exp lrc, exp count, exp err
    vecs[0] = mkv(1, 44'h0000_0000_007, '0, '0, 1'b0, 1'b0, '0,
                  1'b1, 44'h7, 1, 1'b0);
    vecs[1] = mkv(1, 44'h0000_0000_007, '0, '0, 1'b1, 1'b0, '0,
                  1'b0, 44'h7, 1, 1'b0);
    vecs[2] = mkv(3, 44'hFFF_FFFF_FFFF, 44'h1, 44'h1, 1'b0, 1'b1, 44'hFFF_FFFF_FFFF,
                  1'b0, 44'hFFF_FFFF_FFFF, 3, 1'b0);
    vecs[3] = mkv(3, 44'hFFF_FFFF_FFFF, 44'h1, 44'h1, 1'b0, 1'b1, 44'h0,
                  1'b0, 44'hFFF_FFFF_FFFF, 3, 1'b1);
    vecs[4] = mkv(2, 44'hA5, 44'h5A, '0, 1'b1, 1'b0, 44'h123,
                  1'b1, 44'hFF, 2, 1'b0);
    vecs[5] = mkv(2, 44'h800_0000_0000, 44'h1, '0, 1'b0, 1'b1, 44'h800_0000_0001,
                  1'b0, 44'h800_0000_0001, 2, 1'b0);
    vecs[6] = mkv(3, 44'h1, 44'h2, 44'h4, 1'b1, 1'b1, 44'h6,
                  1'b0, 44'h7, 3, 1'b1);

    @(negedge clk);
    do_reset();
    check_idle("rst_init");

    // Reset three words into a frame: the partial frame is discarded.
    send_word(44'h10, 1'b0, 1'b0, 1'b0, '0);
    send_word(44'h20, 1'b0, 1'b0, 1'b0, '0);
    send_word(44'h40, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    check_idle("rst_mid");
    send_word(44'h7, 1'b1, 1'b0, 1'b0, '0);
    e = '{parity: 1'b1, lrc: 44'h7, count: 5'd1, trunc: 1'b0, err: 1'b0};
    check_result("rst_next", e);
    tick();

    // Table vectors; odd_sel and chk_* are inverted on beats where they must be ignored.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].nwords; j++) begin
        if (j == vecs[i].nwords - 1)
          send_word(vecs[i].w[j], 1'b1, (j == 0) ? vecs[i].odd : !vecs[i].odd,
                    vecs[i].chk_en, vecs[i].chk_lrc);
        else
          send_word(vecs[i].w[j], 1'b0, (j == 0) ? vecs[i].odd : !vecs[i].odd,
                    !vecs[i].chk_en, ~vecs[i].chk_lrc);
      end
      check_result($sformatf("tbl%0d", i), vecs[i].exp);
      tick();
      check($sformatf("tbl%0d_drain", i), 64'(m_valid), 64'(0));
    end

    // Truncation: 20 words of 1, s_last only on the 20th.
    for (int k = 1; k <= 20; k++) begin
      send_word(44'h1, (k == 20), 1'b0, 1'b0, '0);
      if (k == 16) begin
        e = '{parity: 1'b0, lrc: 44'h0, count: 5'd16, trunc: 1'b1, err: 1'b0};
        check_result("trunc_first", e);
      end
    end
    e = '{parity: 1'b0, lrc: 44'h0, count: 5'd4, trunc: 1'b0, err: 1'b0};
    check_result("trunc_second", e);
    tick();

    // Backpressure: result held five cycles, then taken together with a new single-word frame.
    m_ready = 1'b0;
    send_word(44'h5, 1'b1, 1'b0, 1'b0, '0);
    s_valid = 1'b1;
    s_data  = 44'h3;
    s_last  = 1'b1;
    odd_sel = 1'b0;
    chk_en  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_s_ready", 64'(s_ready), 64'(0));
      check("bp_m_valid", 64'(m_valid), 64'(1));
      check("bp_m_lrc",   64'(m_lrc),   64'(44'h5));
      check("bp_m_count", 64'(m_count), 64'(1));
      tick();
    end
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    e = '{parity: 1'b0, lrc: 44'h3, count: 5'd1, trunc: 1'b0, err: 1'b0};
    check_result("bp_b2b", e);
    tick();

    // Randomized frames with input gaps and random downstream stalls.
    words_in  = 0;
    count_out = 0;
    rnd_ready = 1'b1;
    for (int f = 0; f < 2000; f++) begin
      len  = $urandom_range(1, 20);
      flrc = '0;
      for (int j = 0; j < len; j++) begin
        rnd   = {$urandom(), $urandom()};
        fw[j] = rnd[N-1:0];
        flrc  = flrc ^ fw[j];
      end
      rnd = {$urandom(), $urandom()};
      fcl = ($urandom_range(0, 1) != 0) ? flrc : rnd[N-1:0];
      fce = ($urandom_range(0, 1) != 0);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          n = $urandom_range(1, 3);
          for (int g = 0; g < n; g++) tick();
        end
        send_word(fw[j], (j == len - 1), ($urandom_range(0, 1) != 0), fce, fcl);
      end
    end
    rnd_ready = 1'b0;
    m_ready   = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("rnd_drain_queue", 64'(exp_q.size()), 64'(0));
    #1;
    check("rnd_drain_valid", 64'(m_valid), 64'(0));
    check("rnd_no_loss", 64'(count_out), 64'(words_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parity_frame_acc
